// File: rtl/user_axil_pkg.sv
// Shared types and constants for the user AXI4-Lite read master.
package user_axil_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StOut
    } state_e;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [31:0] ADDR_STRIDE = 32'd4;

endpackage

// File: rtl/user_axil_watchdog.sv
// Per-phase cycle counter; expired fires on the TIMEOUT-th enabled cycle after a clear.
module user_axil_watchdog #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TO_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam bit            ENABLED = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] LIMIT = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter is zero on the first cycle of a phase, so LIMIT is TIMEOUT-1.
    assign expired = ENABLED && enable && (cnt_q == LIMIT);

endmodule

// File: rtl/user_maxil_read_master.sv
// AXI4-Lite read master: one outstanding single-beat read per word of a command,
// results returned on a valid/ready stream with a watchdog against hung slaves.
module user_maxil_read_master
    import user_axil_pkg::*;
#(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TO_W    = 16
) (
    input  logic             user_maxil_clk,
    input  logic             user_maxil_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [31:0]      user_port_araddr,
    output logic             user_port_arvalid,
    input  logic             user_port_arready,
    input  logic             user_port_rvalid,
    output logic             user_port_rready,
    input  logic [31:0]      user_port_rdata,
    input  logic [1:0]       user_port_rresp,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      rd_data,
    output logic [1:0]       rd_resp,
    output logic             rd_last,
    output logic             busy,
    output logic             err
);

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       resp_q, resp_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic             wd_clear, wd_enable, wd_expired;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        resp_d  = resp_q;
        last_d  = last_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr & ~32'h3;
                    rem_d   = cmd_len;
                    err_d   = 1'b0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (user_port_arready) begin
                    state_d = StData;
                end else if (wd_expired) begin
                    data_d  = '0;
                    resp_d  = RESP_DECERR;
                    last_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = StOut;
                end
            end
            StData: begin
                if (user_port_rvalid) begin
                    data_d  = user_port_rdata;
                    resp_d  = user_port_rresp;
                    last_d  = (rem_q == '0);
                    if (user_port_rresp != RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    state_d = StOut;
                end else if (wd_expired) begin
                    data_d  = '0;
                    resp_d  = RESP_DECERR;
                    last_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = StOut;
                end
            end
            StOut: begin
                if (rd_ready) begin
                    if (last_q) begin
                        state_d = StIdle;
                    end else begin
                        rem_d   = rem_q - LEN_W'(1);
                        addr_d  = addr_q + ADDR_STRIDE;
                        state_d = StAddr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge user_maxil_clk or negedge user_maxil_rst_n) begin
        if (!user_maxil_rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            resp_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Any state change restarts the per-phase budget.
    assign wd_clear  = (state_d != state_q);
    assign wd_enable = (state_q == StAddr) || (state_q == StData);

    user_axil_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk     (user_maxil_clk),
        .rst_n   (user_maxil_rst_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    assign cmd_ready         = (state_q == StIdle);
    assign busy              = (state_q != StIdle);
    assign user_port_arvalid = (state_q == StAddr);
    assign user_port_rready  = (state_q == StData);
    assign user_port_araddr  = addr_q;
    assign rd_valid          = (state_q == StOut);
    assign rd_data           = data_q;
    assign rd_resp           = resp_q;
    assign rd_last           = last_q;
    assign err               = err_q;

endmodule

// File: tb/tb_user_maxil_read_master.sv
// Scoreboard bench: a behavioural AXI-Lite slave plus per-scenario tasks.
module tb_user_maxil_read_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        rd_last;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    user_maxil_read_master #(
        .LEN_W   (8),
        .TIMEOUT (16),
        .TO_W    (16)
    ) dut (
        .user_maxil_clk    (clk),
        .user_maxil_rst_n  (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_addr          (cmd_addr),
        .cmd_len           (cmd_len),
        .user_port_araddr  (araddr),
        .user_port_arvalid (arvalid),
        .user_port_arready (arready),
        .user_port_rvalid  (rvalid),
        .user_port_rready  (rready),
        .user_port_rdata   (rdata),
        .user_port_rresp   (rresp),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready),
        .rd_data           (rd_data),
        .rd_resp           (rd_resp),
        .rd_last           (rd_last),
        .busy              (busy),
        .err               (err)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] ar_log[$];
    int          passed = 0;
    int          total = 0;

    // Slave model state
    bit          ar_hang = 1'b0;
    int          err_beat = 0;
    int          beat_no = 0;
    bit          pending = 1'b0;
    bit          ar_hs = 1'b0;
    bit          r_hs = 1'b0;
    logic [31:0] pend_addr = '0;
    int          arwait = 0;
    int          rwait = 0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Handshakes are decided at negedge; DUT outputs are stable until the next posedge.
    always begin
        @(negedge clk);
        if (!rst_n) begin
            pending = 0; ar_hs = 0; r_hs = 0; arready = 0; rvalid = 0;
            arwait = 0; rwait = 0;
        end else begin
            if (ar_hs) begin pending = 1; ar_hs = 0; rwait = $urandom_range(0, 3); end
            if (r_hs) begin pending = 0; r_hs = 0; end
            arready = 0;
            rvalid = 0;
            if (!pending && arvalid && !ar_hang) begin
                if (arwait == 0) begin
                    arready = 1; ar_hs = 1; pend_addr = araddr;
                    ar_log.push_back(araddr);
                    beat_no++;
                    arwait = $urandom_range(0, 3);
                end else begin
                    arwait--;
                end
            end
            if (pending) begin
                if (rwait == 0) begin
                    rvalid = 1;
                    rdata = data_of(pend_addr);
                    rresp = (beat_no == err_beat) ? 2'b10 : 2'b00;
                    if (rready) r_hs = 1;
                end else begin
                    rwait--;
                end
            end
        end
    end

    task automatic push_expected(input logic [31:0] addr, input int len, input int ebeat);
        logic [31:0] a;
        beat_t b;
        a = addr & ~32'h3;
        for (int i = 0; i <= len; i++) begin
            b.data = data_of(a);
            b.resp = (i + 1 == ebeat) ? 2'b10 : 2'b00;
            b.last = (i == len);
            exp_q.push_back(b);
            exp_addr.push_back(a);
            a = a + 32'd4;
        end
    endtask

    // Returns at the first negedge after acceptance (DUT in ADDR).
    task automatic send_cmd(input logic [31:0] addr, input int len, input int ebeat);
        err_beat = ebeat;
        beat_no = 0;
        ar_log.delete();
        @(negedge clk);
        cmd_valid = 1; cmd_addr = addr; cmd_len = 8'(len);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_rd(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (rd_valid) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic handshake_rd();
        rd_ready = 1;
        @(negedge clk);
        rd_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        total++;
        if ({cmd_ready, arvalid, rready, rd_valid, busy, err, rd_last, rd_resp, rd_data, araddr}
            !== {1'b1, 6'b0, 2'b0, 32'h0, 32'h0})
            $display("FAIL reset_state: cmd_ready=%b arvalid=%b busy=%b araddr=%h, want only cmd_ready=1",
                     cmd_ready, arvalid, busy, araddr);
        else passed++;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        beat_t b;
        push_expected(32'h1000, 0, 0);
        send_cmd(32'h1000, 0, 0);
        total++;
        if ({arvalid, araddr} !== {1'b1, 32'h1000})
            $display("FAIL basic_ar: arvalid=%b araddr=%h want 1 00001000", arvalid, araddr);
        else passed++;
        wait_rd(ok);
        total++;
        if (!ok) begin $display("FAIL basic_timeout: rd_valid never rose"); return; end
        b = exp_q.pop_front();
        if ({rd_data, rd_resp, rd_last, err} !== {b.data, b.resp, b.last, 1'b0})
            $display("FAIL basic_beat: got %h/%b/%b err=%b want %h/%b/%b err=0",
                     rd_data, rd_resp, rd_last, err, b.data, b.resp, b.last);
        else passed++;
        handshake_rd();
        total++;
        if ({busy, cmd_ready} !== 2'b01)
            $display("FAIL basic_idle: busy=%b cmd_ready=%b want 0 1", busy, cmd_ready);
        else passed++;
        total++;
        if (ar_log.size() != 1 || ar_log[0] !== exp_addr.pop_front())
            $display("FAIL basic_arlog: %0d ARs seen, want 1 at 00001000", ar_log.size());
        else passed++;
    endtask

    task automatic test_burst();
        bit ok;
        beat_t b;
        int n;
        push_expected(32'h2003, 3, 0);
        send_cmd(32'h2003, 3, 0);
        for (int i = 0; i < 4; i++) begin
            wait_rd(ok);
            total++;
            if (!ok) begin $display("FAIL burst_timeout: beat %0d missing", i); return; end
            b = exp_q.pop_front();
            if ({rd_data, rd_resp, rd_last} !== {b.data, b.resp, b.last})
                $display("FAIL burst_beat%0d: got %h/%b/%b want %h/%b/%b",
                         i, rd_data, rd_resp, rd_last, b.data, b.resp, b.last);
            else passed++;
            handshake_rd();
        end
        n = ar_log.size();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = exp_addr.pop_front();
            total++;
            if (i >= n || ar_log[i] !== e)
                $display("FAIL burst_araddr%0d: got %h want %h", i, (i < n) ? ar_log[i] : 32'hx, e);
            else passed++;
        end
        total++;
        if (n != 4 || busy !== 1'b0)
            $display("FAIL burst_count: %0d ARs busy=%b want 4 ARs busy=0", n, busy);
        else passed++;
    endtask

    task automatic test_backpressure_wrap();
        bit ok;
        bit stable;
        beat_t b;
        push_expected(32'hFFFF_FFF8, 2, 0);
        send_cmd(32'hFFFF_FFF8, 2, 0);
        for (int i = 0; i < 3; i++) begin
            wait_rd(ok);
            total++;
            if (!ok) begin $display("FAIL bp_timeout: beat %0d missing", i); return; end
            b = exp_q.pop_front();
            stable = 1;
            for (int c = 0; c < 5; c++) begin
                if ({rd_valid, arvalid, rd_data, rd_last} !== {1'b1, 1'b0, b.data, b.last})
                    stable = 0;
                @(negedge clk);
            end
            if (!stable || {rd_data, rd_resp, rd_last} !== {b.data, b.resp, b.last})
                $display("FAIL bp_beat%0d: stable=%b got %h/%b/%b want %h/%b/%b",
                         i, stable, rd_data, rd_resp, rd_last, b.data, b.resp, b.last);
            else passed++;
            handshake_rd();
        end
        total++;
        if (ar_log.size() != 3 || ar_log[0] !== exp_addr[0] || ar_log[1] !== exp_addr[1]
            || ar_log[2] !== exp_addr[2])
            $display("FAIL bp_araddr: %0d ARs, want FFFFFFF8 FFFFFFFC 00000000", ar_log.size());
        else passed++;
        exp_addr.delete();
    endtask

    task automatic test_slave_error();
        bit ok;
        beat_t b;
        push_expected(32'h3000, 2, 2);
        send_cmd(32'h3000, 2, 2);
        for (int i = 0; i < 3; i++) begin
            wait_rd(ok);
            total++;
            if (!ok) begin $display("FAIL slverr_timeout: beat %0d missing", i); return; end
            b = exp_q.pop_front();
            if ({rd_data, rd_resp, rd_last, err} !== {b.data, b.resp, b.last, (i >= 1)})
                $display("FAIL slverr_beat%0d: got %h/%b/%b err=%b want %h/%b/%b err=%b",
                         i, rd_data, rd_resp, rd_last, err, b.data, b.resp, b.last, (i >= 1));
            else passed++;
            handshake_rd();
        end
        total++;
        if (err !== 1'b1 || ar_log.size() != 3)
            $display("FAIL slverr_sticky: err=%b ARs=%0d want 1 3", err, ar_log.size());
        else passed++;
        exp_addr.delete();
        push_expected(32'h4000, 0, 0);
        send_cmd(32'h4000, 0, 0);
        total++;
        if (err !== 1'b0) $display("FAIL slverr_clear: err=%b want 0", err);
        else passed++;
        wait_rd(ok);
        total++;
        if (!ok) begin $display("FAIL slverr_next_timeout: no beat"); return; end
        b = exp_q.pop_front();
        if ({rd_data, rd_resp, rd_last} !== {b.data, b.resp, b.last})
            $display("FAIL slverr_next_beat: got %h/%b/%b want %h/%b/%b",
                     rd_data, rd_resp, rd_last, b.data, b.resp, b.last);
        else passed++;
        handshake_rd();
        exp_addr.delete();
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        beat_t b;
        ar_hang = 1;
        b.data = '0; b.resp = 2'b11; b.last = 1'b1;
        exp_q.push_back(b);
        send_cmd(32'h5000, 3, 0);
        cnt = 0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (rd_valid) begin ok = 1; break; end
            if (arvalid) cnt++;
            @(negedge clk);
        end
        total++;
        if (!ok || cnt != 16)
            $display("FAIL timeout_arvalid: high %0d cycles (done=%b) want 16", cnt, ok);
        else passed++;
        if (!ok) begin ar_hang = 0; return; end
        b = exp_q.pop_front();
        total++;
        if ({rd_data, rd_resp, rd_last, err} !== {b.data, b.resp, b.last, 1'b1})
            $display("FAIL timeout_beat: got %h/%b/%b err=%b want 00000000/11/1 err=1",
                     rd_data, rd_resp, rd_last, err);
        else passed++;
        handshake_rd();
        total++;
        if ({busy, cmd_ready, err} !== 3'b011 || ar_log.size() != 0)
            $display("FAIL timeout_idle: busy=%b cmd_ready=%b err=%b ARs=%0d want 0 1 1 0",
                     busy, cmd_ready, err, ar_log.size());
        else passed++;
        ar_hang = 0;
    endtask

    task automatic test_async_reset();
        bit ok;
        beat_t b;
        send_cmd(32'h6000, 7, 0);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (rready) begin ok = 1; break; end
            @(negedge clk);
        end
        total++;
        if (!ok) begin $display("FAIL areset_data: DATA never reached"); return; end
        #2 rst_n = 0;
        #1;
        if ({cmd_ready, arvalid, rready, rd_valid, busy, err, rd_last, rd_resp, rd_data, araddr}
            !== {1'b1, 6'b0, 2'b0, 32'h0, 32'h0})
            $display("FAIL areset_outputs: arvalid=%b rready=%b busy=%b araddr=%h cmd_ready=%b",
                     arvalid, rready, busy, araddr, cmd_ready);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        exp_q.delete();
        exp_addr.delete();
        @(negedge clk);
        total++;
        if ({cmd_ready, busy, arvalid} !== 3'b100)
            $display("FAIL areset_release: cmd_ready=%b busy=%b arvalid=%b want 1 0 0",
                     cmd_ready, busy, arvalid);
        else passed++;
        push_expected(32'h7000, 1, 0);
        send_cmd(32'h7000, 1, 0);
        for (int i = 0; i < 2; i++) begin
            wait_rd(ok);
            total++;
            if (!ok) begin $display("FAIL areset_rerun_timeout: beat %0d", i); return; end
            b = exp_q.pop_front();
            if ({rd_data, rd_resp, rd_last} !== {b.data, b.resp, b.last})
                $display("FAIL areset_rerun%0d: got %h/%b/%b want %h/%b/%b",
                         i, rd_data, rd_resp, rd_last, b.data, b.resp, b.last);
            else passed++;
            handshake_rd();
        end
        total++;
        if (ar_log.size() != 2 || ar_log[0] !== 32'h7000 || ar_log[1] !== 32'h7004)
            $display("FAIL areset_rerun_araddr: %0d ARs, want 00007000 00007004", ar_log.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_burst();
        test_backpressure_wrap();
        test_slave_error();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
